// File: rtl/serial_add_mux_unit.sv
// serial_add_mux_unit: NUM_CH-way operand mux feeding a bit-serial full adder, one bit per clock.
// Define SUBTRACT_EN to add the sub_i port (A - B via inverted B and forced carry-in).
module serial_add_mux_unit #(
    parameter int WIDTH = 8,
    parameter int NUM_CH = 4,
    localparam int SEL_W = $clog2(NUM_CH)
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic                    start_i,
    input  logic [SEL_W-1:0]        sel_a_i,
    input  logic [SEL_W-1:0]        sel_b_i,
    input  logic [NUM_CH*WIDTH-1:0] ch_data_i,
    input  logic                    cin_i,
`ifdef SUBTRACT_EN
    input  logic                    sub_i,
`endif
    output logic                    busy_o,
    output logic                    done_o,
    output logic [WIDTH-1:0]        sum_o,
    output logic                    cout_o,
    output logic                    overflow_o
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, acc_q, acc_d, sum_q, sum_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d, cout_q, cout_d, ovf_q, ovf_d;
    logic             sub, s, c, last;
    logic [WIDTH-1:0] ch [2**SEL_W];

    // Unused select codes beyond NUM_CH read as an all-zero operand.
    for (genvar g = 0; g < 2**SEL_W; g++) begin : g_ch
        if (g < NUM_CH) begin : g_used
            assign ch[g] = ch_data_i[g*WIDTH +: WIDTH];
        end else begin : g_zero
            assign ch[g] = '0;
        end
    end

`ifdef SUBTRACT_EN
    assign sub = sub_i;
`else
    assign sub = 1'b0;
`endif

    assign s = a_q[0] ^ b_q[0] ^ carry_q;
    assign c = (a_q[0] & b_q[0]) | (carry_q & (a_q[0] ^ b_q[0]));
    assign last = cnt_q == CW'(WIDTH - 1);

    always_comb begin
        state_d = state_q;
        a_d = a_q;
        b_d = b_q;
        acc_d = acc_q;
        cnt_d = cnt_q;
        carry_d = carry_q;
        sum_d = sum_q;
        cout_d = cout_q;
        ovf_d = ovf_q;
        if (state_q == IDLE && start_i) begin
            state_d = SHIFT;
            a_d = ch[sel_a_i];
            b_d = sub ? ~ch[sel_b_i] : ch[sel_b_i];
            carry_d = sub | cin_i;
            cnt_d = '0;
        end else if (state_q == SHIFT) begin
            a_d = a_q >> 1;
            b_d = b_q >> 1;
            acc_d = {s, acc_q[WIDTH-1:1]};
            carry_d = c;
            cnt_d = cnt_q + CW'(1);
            // carry_q here is the carry into the MSB on the final bit
            if (last) begin
                state_d = DONE;
                sum_d = {s, acc_q[WIDTH-1:1]};
                cout_d = c;
                ovf_d = carry_q ^ c;
            end
        end else begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            state_q <= IDLE;
            a_q <= '0;
            b_q <= '0;
            acc_q <= '0;
            cnt_q <= '0;
            carry_q <= 1'b0;
            sum_q <= '0;
            cout_q <= 1'b0;
            ovf_q <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q <= a_d;
            b_q <= b_d;
            acc_q <= acc_d;
            cnt_q <= cnt_d;
            carry_q <= carry_d;
            sum_q <= sum_d;
            cout_q <= cout_d;
            ovf_q <= ovf_d;
        end
    end

    assign busy_o = state_q == SHIFT || state_q == DONE;
    assign done_o = state_q == DONE;
    assign sum_o = sum_q;
    assign cout_o = cout_q;
    assign overflow_o = ovf_q;
endmodule

// File: tb/tb_serial_add_mux_unit.sv
// tb_serial_add_mux_unit: directed vector table plus hand-written handshake, hold and reset-abort sequences.
module tb_serial_add_mux_unit;
    logic        clk = 1'b0;
    logic        reset_i, start_i, cin_i, sub_i;
    logic [1:0]  sel_a_i, sel_b_i;
    logic [31:0] ch_data_i;
    logic        busy_o, done_o, cout_o, overflow_o;
    logic [7:0]  sum_o;
    int          errors = 0;
    int          checks = 0;

    serial_add_mux_unit #(.WIDTH(8), .NUM_CH(4)) dut (
        .clk_i(clk), .reset_i(reset_i), .start_i(start_i),
        .sel_a_i(sel_a_i), .sel_b_i(sel_b_i), .ch_data_i(ch_data_i), .cin_i(cin_i),
`ifdef SUBTRACT_EN
        .sub_i(sub_i),
`endif
        .busy_o(busy_o), .done_o(done_o), .sum_o(sum_o), .cout_o(cout_o), .overflow_o(overflow_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] a, b;
        logic [1:0] sa, sb;
        logic       ci, sub;
        logic [7:0] s;
        logic       co, ov;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Waits for done after the start edge; returns edges waited and busy samples seen.
    task automatic wait_done(output int n, output int bc);
        n = 0;
        bc = int'(busy_o);
        while (!done_o && n < 20) begin
            tick();
            n++;
            bc += int'(busy_o);
        end
        chk("done_seen", {31'd0, done_o}, 32'd1);
    endtask

    task automatic run_vec(input vec_t v);
        int n, bc;
        ch_data_i = 32'hA5A5_A5A5;
        ch_data_i[v.sa*8 +: 8] = v.a;
        ch_data_i[v.sb*8 +: 8] = v.b;
        sel_a_i = v.sa;
        sel_b_i = v.sb;
        cin_i = v.ci;
        sub_i = v.sub;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        ch_data_i = 32'h0;
        wait_done(n, bc);
        chk("latency", n, 8);
        chk("busy_cycles", bc, 9);
        chk("sum", {24'd0, sum_o}, {24'd0, v.s});
        chk("cout", {31'd0, cout_o}, {31'd0, v.co});
        chk("overflow", {31'd0, overflow_o}, {31'd0, v.ov});
        tick();
        chk("done_pulse_end", {30'd0, busy_o, done_o}, 32'd0);
    endtask

    initial begin
        int n, bc, dones;
        vecs.push_back('{8'h0F, 8'h01, 2'd0, 2'd1, 1'b0, 1'b0, 8'h10, 1'b0, 1'b0});
        vecs.push_back('{8'hFF, 8'h01, 2'd2, 2'd3, 1'b1, 1'b0, 8'h01, 1'b1, 1'b0});
        vecs.push_back('{8'h7F, 8'h01, 2'd0, 2'd1, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1});
        vecs.push_back('{8'h80, 8'h80, 2'd1, 2'd2, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1});
        vecs.push_back('{8'h55, 8'hAA, 2'd3, 2'd0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0});
        vecs.push_back('{8'h40, 8'h40, 2'd2, 2'd2, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1});
        vecs.push_back('{8'h00, 8'h00, 2'd1, 2'd3, 1'b1, 1'b0, 8'h01, 1'b0, 1'b0});
        vecs.push_back('{8'hC8, 8'h64, 2'd0, 2'd3, 1'b0, 1'b0, 8'h2C, 1'b1, 1'b0});
`ifdef SUBTRACT_EN
        vecs.push_back('{8'h05, 8'h07, 2'd0, 2'd1, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0});
        vecs.push_back('{8'h80, 8'h01, 2'd2, 2'd3, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1});
        vecs.push_back('{8'h80, 8'h01, 2'd2, 2'd3, 1'b1, 1'b1, 8'h7F, 1'b1, 1'b1});
        vecs.push_back('{8'h0F, 8'h01, 2'd0, 2'd1, 1'b0, 1'b0, 8'h10, 1'b0, 1'b0});
`endif
        reset_i = 1'b0;
        start_i = 1'b1;
        sel_a_i = 2'd0;
        sel_b_i = 2'd1;
        cin_i = 1'b1;
        sub_i = 1'b0;
        ch_data_i = 32'h0000_FFFF;
        repeat (3) tick();
        chk("rst_busy", {31'd0, busy_o}, 32'd0);
        chk("rst_done", {31'd0, done_o}, 32'd0);
        chk("rst_sum", {24'd0, sum_o}, 32'd0);
        chk("rst_cout", {31'd0, cout_o}, 32'd0);
        chk("rst_ovf", {31'd0, overflow_o}, 32'd0);
        start_i = 1'b0;
        reset_i = 1'b1;
        tick();

        foreach (vecs[i]) run_vec(vecs[i]);

        // start held high; operands changed mid-shift must not affect the running op
        ch_data_i = 32'h0000_010F;
        sel_a_i = 2'd0;
        sel_b_i = 2'd1;
        cin_i = 1'b0;
        sub_i = 1'b0;
        start_i = 1'b1;
        tick();
        ch_data_i = 32'h0000_3322;
        sel_a_i = 2'd1;
        sel_b_i = 2'd0;
        cin_i = 1'b0;
        wait_done(n, bc);
        chk("hold_latency", n, 8);
        chk("hold_sum", {24'd0, sum_o}, 32'h10);
        tick();
        chk("hold_idle", {30'd0, busy_o, done_o}, 32'd0);
        tick();
        chk("b2b_accept", {31'd0, busy_o}, 32'd1);
        start_i = 1'b0;
        ch_data_i = 32'hFFFF_FFFF;
        wait_done(n, bc);
        chk("b2b_latency", n, 8);
        chk("b2b_sum", {24'd0, sum_o}, 32'h55);
        dones = 0;
        repeat (12) begin
            tick();
            dones += int'(done_o);
        end
        chk("b2b_extra_done", dones, 0);
        chk("b2b_sum_held", {24'd0, sum_o}, 32'h55);

        // reset on the 4th SHIFT cycle aborts and clears the previous result
        ch_data_i = 32'h0000_010F;
        sel_a_i = 2'd0;
        sel_b_i = 2'd1;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        repeat (3) tick();
        chk("abort_pre_sum", {24'd0, sum_o}, 32'h55);
        reset_i = 1'b0;
        tick();
        reset_i = 1'b1;
        chk("abort_busy", {31'd0, busy_o}, 32'd0);
        chk("abort_sum", {24'd0, sum_o}, 32'd0);
        dones = 0;
        repeat (12) begin
            dones += int'(done_o);
            tick();
        end
        chk("abort_no_done", dones, 0);
        chk("abort_sum_held", {24'd0, sum_o}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
